// File: rtl/count_event_logger.sv
// ---------------------------------------------------------------------------
// count_event_logger
//
// Watches the 4-bit free-running counter and logs interesting changes of its
// value. Every clock the current count is compared with the previous sample
// and classified as WRAP (15 -> 0), MATCH (normal +1 step onto cmp_value
// while cmp_en is set) or JUMP (any other change). Each event is stamped
// with a free-running timestamp and pushed into a small FIFO that a consumer
// drains through a valid/ready handshake.
//
// Parameters:
//   DEPTH      FIFO entries, power of two in 2..16
//   TS_W       timestamp width in bits
//
// Ports:
//   clk        rising-edge clock, shared with the counter
//   reset      asynchronous, active-high reset
//   count_in   counter value to monitor
//   cmp_en     enables MATCH detection
//   cmp_value  compare value for MATCH
//   evt_ready  consumer accepts the head entry
//   ovf_clr    synchronous clear of the sticky overflow flag
//   evt_valid  FIFO holds at least one entry
//   evt_code   head event type: 0 = WRAP, 1 = MATCH, 2 = JUMP
//   evt_count  count_in value that caused the head event
//   evt_stamp  timestamp of the head event
//   fifo_level current FIFO occupancy
//   overflow   sticky flag, set when an event had to be dropped
// ---------------------------------------------------------------------------
module count_event_logger #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              count_in,
    input  logic                    cmp_en,
    input  logic [3:0]              cmp_value,
    input  logic                    evt_ready,
    input  logic                    ovf_clr,
    output logic                    evt_valid,
    output logic [1:0]              evt_code,
    output logic [3:0]              evt_count,
    output logic [TS_W-1:0]         evt_stamp,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        EVT_WRAP  = 2'd0,
        EVT_MATCH = 2'd1,
        EVT_JUMP  = 2'd2
    } evt_code_e;

    typedef struct packed {
        evt_code_e         code;
        logic [3:0]        count;
        logic [TS_W-1:0]   stamp;
    } entry_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [TS_W-1:0]  ts_q,       ts_d;
    logic [3:0]       prev_q,     prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [LVL_W-1:0] level_q,    level_d;
    logic             overflow_q, overflow_d;
    entry_t           head_q,     head_d;
    entry_t           mem_q [DEPTH];

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic             evt_fire;
    evt_code_e        evt_type;
    logic [3:0]       count_step;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             drop;
    logic [PTR_W-1:0] rd_next;
    entry_t           new_entry;

    // Classification of the current sample against the previous one.
    // A step that is not exactly +1 (mod 16) is a JUMP and beats everything,
    // so a jump landing on cmp_value is never reported as MATCH. The +1 step
    // out of 15 is the wrap and beats MATCH, so cmp_value = 0 yields WRAP only.
    always_comb begin
        evt_fire   = 1'b0;
        evt_type   = EVT_WRAP;
        count_step = prev_q + 4'd1;
        if (prev_vld_q && (count_in != prev_q)) begin
            if (count_in != count_step) begin
                evt_fire = 1'b1;
                evt_type = EVT_JUMP;
            end else if (prev_q == 4'hF) begin
                evt_fire = 1'b1;
                evt_type = EVT_WRAP;
            end else if (cmp_en && (count_in == cmp_value)) begin
                evt_fire = 1'b1;
                evt_type = EVT_MATCH;
            end
        end
    end

    // FIFO control. A pop frees a slot on the same edge, so a full FIFO still
    // accepts a new event when the consumer is taking the head at that edge.
    // The head entry is kept in its own register so the outputs never depend
    // combinationally on count_in and simply hold their value while empty.
    always_comb begin
        fifo_full  = (level_q == LVL_W'(DEPTH));
        fifo_empty = (level_q == '0);
        pop        = !fifo_empty && evt_ready;
        push       = evt_fire && (!fifo_full || pop);
        drop       = evt_fire && fifo_full && !pop;
        rd_next    = rd_ptr_q + PTR_W'(1);

        new_entry.code  = evt_type;
        new_entry.count = count_in;
        new_entry.stamp = ts_q;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        head_d   = head_q;

        if (pop) begin
            rd_ptr_d = rd_next;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // The next head is the following stored entry if one exists,
        // otherwise the entry being pushed right now (empty FIFO, or the
        // last stored entry leaving on the same edge).
        if (pop && (level_q > LVL_W'(1))) begin
            head_d = mem_q[rd_next];
        end else if (push && (fifo_empty || (pop && (level_q == LVL_W'(1))))) begin
            head_d = new_entry;
        end

        // A drop on the same edge as a clear leaves the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        ts_d       = ts_q + TS_W'(1);
        prev_d     = count_in;
        prev_vld_d = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Registers with asynchronous reset. Reset empties the FIFO by clearing
    // the pointers and level; stale array contents are never observed.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q       <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            head_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            head_q     <= head_d;
        end
    end

    // Storage array. When full with a simultaneous pop, wr_ptr equals rd_ptr
    // and the slot being overwritten is the one the consumer just took.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign evt_valid  = !fifo_empty;
    assign evt_code   = head_q.code;
    assign evt_count  = head_q.count;
    assign evt_stamp  = head_q.stamp;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_count_event_logger.sv
// ---------------------------------------------------------------------------
// Testbench for count_event_logger.
// A reference model classifies every driven sample; expected FIFO entries go
// into a scoreboard queue and are compared when the DUT hands out its head.
// ---------------------------------------------------------------------------
module tb_count_event_logger;

    localparam int DEPTH = 4;
    localparam int TS_W  = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [3:0]             count_in;
    logic                   cmp_en;
    logic [3:0]             cmp_value;
    logic                   evt_ready;
    logic                   ovf_clr;
    logic                   evt_valid;
    logic [1:0]             evt_code;
    logic [3:0]             evt_count;
    logic [TS_W-1:0]        evt_stamp;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overflow;

    count_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .cmp_en     (cmp_en),
        .cmp_value  (cmp_value),
        .evt_ready  (evt_ready),
        .ovf_clr    (ovf_clr),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_count  (evt_count),
        .evt_stamp  (evt_stamp),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int count;
        int stamp;
    } exp_t;

    exp_t sb[$];

    int compared    = 0;
    int mismatched  = 0;
    int mTs         = 0;
    int mPrev       = 0;
    bit mPrevVld    = 1'b0;
    bit mOvf        = 1'b0;
    int poppedWraps = 0;
    int lastWrapStamp = -1;
    bit freeRun     = 1'b0;

    // Counts one comparison and reports it when the values differ (X aware).
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference classification: -1 = none, 0 = WRAP, 1 = MATCH, 2 = JUMP.
    function automatic int classify(input int prev, input int cur, input bit en, input int cv);
        int diff;
        diff = (cur - prev) & 15;
        if (diff == 0) return -1;
        if (diff != 1) return 2;
        if (cur == 0)  return 0;
        if (en && (cur == cv)) return 1;
        return -1;
    endfunction

    task automatic modelReset();
        sb.delete();
        mTs      = 0;
        mPrev    = 0;
        mPrevVld = 1'b0;
        mOvf     = 1'b0;
    endtask

    // Drives one cycle of inputs, updates the model, lets one edge pass and
    // checks the occupancy/flag outputs against the model.
    task automatic applyStimulus(input int cnt, input bit en, input int cv, input bit rdy, input bit clr);
        int   code;
        bit   full;
        bit   pop;
        exp_t e;
        exp_t n;
        count_in  = 4'(cnt);
        cmp_en    = en;
        cmp_value = 4'(cv);
        evt_ready = rdy;
        ovf_clr   = clr;
        full = (sb.size() == DEPTH);
        pop  = (sb.size() != 0) && rdy;
        if (pop) begin
            e = sb.pop_front();
            checkOutput("head_code",  32'(evt_code),  32'(e.code));
            checkOutput("head_count", 32'(evt_count), 32'(e.count));
            checkOutput("head_stamp", 32'(evt_stamp), 32'(e.stamp));
            if (e.code == 0 && freeRun) begin
                poppedWraps++;
                if (lastWrapStamp >= 0)
                    checkOutput("wrap_stamp_delta", 32'((int'(evt_stamp) - lastWrapStamp) & 255), 32'd16);
                lastWrapStamp = int'(evt_stamp);
            end
        end
        code = mPrevVld ? classify(mPrev, cnt, en, cv) : -1;
        if (code >= 0 && full && !pop) begin
            mOvf = 1'b1;
        end else begin
            if (code >= 0) begin
                n.code  = code;
                n.count = cnt;
                n.stamp = mTs;
                sb.push_back(n);
            end
            if (clr) mOvf = 1'b0;
        end
        mPrev    = cnt;
        mPrevVld = 1'b1;
        mTs      = (mTs + 1) & 255;
        @(posedge clk);
        #1;
        checkOutput("level",    32'(fifo_level), 32'(sb.size()));
        checkOutput("valid",    32'(evt_valid),  32'(sb.size() != 0));
        checkOutput("overflow", 32'(overflow),   32'(mOvf));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"},    32'(evt_valid),  32'd0);
        checkOutput({tag, "_level"},    32'(fifo_level), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow),   32'd0);
        checkOutput({tag, "_code"},     32'(evt_code),   32'd0);
        checkOutput({tag, "_count"},    32'(evt_count),  32'd0);
        checkOutput({tag, "_stamp"},    32'(evt_stamp),  32'd0);
    endtask

    // Pulses reset for 3 ns in the low clock phase, away from any edge.
    task automatic midReset();
        @(negedge clk);
        #1 reset = 1'b1;
        #1 checkResetOutputs("midrst");
        #2 reset = 1'b0;
        modelReset();
    endtask

    int seqJump [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 9, 4, 4, 5};
    int seqBp   [5]  = '{10, 2, 10, 2, 10};
    int seqFull [4]  = '{3, 12, 3, 12};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        count_in  = 4'd0;
        cmp_en    = 1'b0;
        cmp_value = 4'd0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        reset = 1'b0;
        modelReset();

        // Free-running wrap, no compare
        $display("[TB] free-run wrap");
        freeRun = 1'b1;
        applyStimulus(0, 0, 0, 1, 0);
        for (int lap = 0; lap < 3; lap++)
            for (int v = 0; v < 16; v++)
                applyStimulus(v, 0, 0, 1, 0);
        freeRun = 1'b0;
        checkOutput("wrap_count", 32'(poppedWraps), 32'd2);

        // Compare match on 5, then compare on 0 (wrap wins)
        $display("[TB] compare match");
        for (int v = 0; v < 16; v++) applyStimulus(v, 1, 5, 1, 0);
        for (int v = 0; v < 16; v++) applyStimulus(v, 1, 0, 1, 0);

        // Jumps and a hold
        $display("[TB] jump");
        foreach (seqJump[i]) applyStimulus(seqJump[i], 0, 0, 1, 0);

        // Backpressure: five events into four slots
        $display("[TB] backpressure");
        foreach (seqBp[i]) applyStimulus(seqBp[i], 0, 0, 0, 0);
        checkOutput("bp_level",    32'(fifo_level), 32'd4);
        checkOutput("bp_overflow", 32'(overflow),   32'd1);
        repeat (5) applyStimulus(10, 0, 0, 1, 0);
        applyStimulus(10, 0, 0, 1, 1);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with a push and a pop on the same edge
        $display("[TB] full push/pop");
        foreach (seqFull[i]) applyStimulus(seqFull[i], 0, 0, 0, 0);
        applyStimulus(5, 0, 0, 1, 0);
        checkOutput("pp_level",    32'(fifo_level), 32'd4);
        checkOutput("pp_overflow", 32'(overflow),   32'd0);
        repeat (5) applyStimulus(5, 0, 0, 1, 0);

        // Reset in the middle of operation with three entries queued
        $display("[TB] mid-operation reset");
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(8, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("pre_rst_level", 32'(fifo_level), 32'd3);
        midReset();
        applyStimulus(9, 0, 0, 0, 0);
        checkOutput("post_rst_no_evt", 32'(evt_valid), 32'd0);
        applyStimulus(3, 0, 0, 0, 0);
        checkOutput("post_rst_stamp", 32'(evt_stamp), 32'd1);
        checkOutput("post_rst_code",  32'(evt_code),  32'd2);
        repeat (3) applyStimulus(3, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/count_event_logger.md
# count_event_logger

Downstream monitor for the 4-bit free-running counter. It samples the counter's `count` output every clock and classifies each change as a wrap, a compare match or a discontinuity (jump, e.g. caused by a counter reset). Each event is tagged with an 8-bit timestamp and queued in a small FIFO, which a consumer drains through a valid/ready handshake.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `TS_W`, default 8: timestamp width in bits.
- `clk`, in, 1: rising-edge clock, shared with the counter.
- `reset`, in, 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `count_in`, in, 4: counter value, registered in the same `clk` domain.
- `cmp_en`, in, 1: enables MATCH detection.
- `cmp_value`, in, 4: compare value for MATCH.
- `evt_ready`, in, 1: consumer accepts the head entry.
- `ovf_clr`, in, 1: synchronous clear of `overflow`.
- `evt_valid`, out, 1: FIFO non-empty.
- `evt_code`, out, 2: head event type: 0 = WRAP, 1 = MATCH, 2 = JUMP, 3 is never produced.
- `evt_count`, out, 4: `count_in` value that caused the head event.
- `evt_stamp`, out, TS_W: timestamp of the head event.
- `fifo_level`, out, clog2(DEPTH)+1: current occupancy.
- `overflow`, out, 1: sticky flag, set when an event is dropped.

## Operation
- **Timestamp.** `ts` is a free-running TS_W-bit counter incrementing every clock. It wraps from 2^TS_W-1 to 0 with no event.
- **Previous sample.** `prev_q` holds the last sample of `count_in`. `prev_vld` is cleared by reset and set after the first post-reset edge. While `prev_vld`=0, the edge only loads `prev_q` and generates no event.
- **Classification** (combinational, `cur` = `count_in`, only when `prev_vld`=1):
  - `cur == prev_q`: no event.
  - `prev_q == 15 && cur == 0`: WRAP.
  - `cur == prev_q + 1` (4-bit arithmetic, no wrap case) and `cmp_en && cur == cmp_value`: MATCH.
  - `cur != prev_q + 1` (mod 16): JUMP, regardless of `cmp_en`.
  - Otherwise: no event.
- **Priority.** At most one event per cycle. JUMP > WRAP > MATCH.
  - A wrap to 0 with `cmp_value`=0 logs WRAP only.
  - A jump landing on `cmp_value` logs JUMP only.
- **Push.** The entry `{code, cur, ts}` is written on the same edge that samples `cur`.
- **Pop.** Occurs when `evt_valid && evt_ready` at an edge. The head entry advances.
- **FIFO full:**
  - Push with simultaneous pop: both occur and the level is unchanged.
  - Push without pop: the event is dropped, `overflow` is set, and stored entries are untouched.
- **FIFO empty.** `evt_ready` is ignored. The `evt_code`/`evt_count`/`evt_stamp` outputs are don't-care, but must hold their last value and not be X.
- **`overflow`.** Cleared by `ovf_clr` at an edge. If a drop and `ovf_clr` coincide, set wins.
- **Reset** (asserted any time, including mid-operation):
  - Immediately forces `evt_valid`=0, `fifo_level`=0, `overflow`=0, `evt_code`=0, `evt_count`=0, `evt_stamp`=0.
  - Internally forces `ts`=0, `prev_vld`=0, `prev_q`=0.
  - All queued events are discarded.

## Timing
- **Event latency.** A change on `count_in` that is valid before edge N appears with `evt_valid`=1 after edge N, provided the FIFO was empty. It carries `evt_stamp` = `ts` value before edge N.
- **Throughput.** One push and one pop per cycle sustained. There is no bubble when `evt_ready` is held high.
- **Head update.** Head outputs change only after a pop edge, or after a push into an empty FIFO. They are registered or read from the array with no combinational path from `count_in`.
- **`fifo_level`.** Updates on the same edge as push/pop. `evt_valid` = (`fifo_level` != 0).
- **Reset release.** After reset deasserts, the first clock edge only loads `prev_q`. The earliest event can be produced on the second edge.

## Test plan
- **Free-run wrap.** Counter 0→15→0 continuously, `cmp_en`=0, `evt_ready`=1.
  - Expect exactly one WRAP per 16 cycles, with `evt_count`=0.
  - Consecutive `evt_stamp` values must differ by 16 mod 256.
- **Compare match.** `cmp_en`=1, `cmp_value`=5.
  - Expect MATCH with `evt_count`=5 once per lap.
  - With `cmp_value`=0, expect WRAP only and no MATCH.
- **Jump.** Counter reset while counting at 7.
  - `count_in` 7→0 gives JUMP with `evt_count`=0.
  - A forced 3→9 gives JUMP.
  - A hold 4→4 gives no event.
- **Backpressure / overflow.** `evt_ready`=0 through 5 events with DEPTH=4.
  - Expect `fifo_level`=4 and `overflow`=1; the 5th event is lost.
  - Then drain: the 4 entries come out in order with the original stamps.
  - `ovf_clr` then returns `overflow` to 0.
- **Full with simultaneous push/pop.** Level 4, `evt_ready`=1 on the same cycle as a new event.
  - Level stays 4, `overflow` stays 0, and the new entry lands at the tail.
- **Mid-operation reset.** Assert `reset` for 3 ns between edges with level=3.
  - Outputs go to 0 immediately.
  - After release: no event on the first edge, and `ts` restarts at 0.
